// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: datapath widths,
// ALU op codes, operand-select encodings and the bypass-match helper.
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 6;

    // ALU_NOP is the bubble encoding, so real ops start at 1
    typedef enum logic [5:0] {
        ALU_NOP  = 6'd0,
        ALU_ADD  = 6'd1,
        ALU_SUB  = 6'd2,
        ALU_OR   = 6'd3,
        ALU_XOR  = 6'd4,
        ALU_AND  = 6'd5,
        ALU_SLL  = 6'd6,
        ALU_SRL  = 6'd7,
        ALU_SRA  = 6'd8,
        ALU_JAL  = 6'd9,
        ALU_JALR = 6'd10,
        ALU_SLT  = 6'd11,
        ALU_SLTU = 6'd12,
        ALU_BLT  = 6'd13,
        ALU_BLTU = 6'd14,
        ALU_BGE  = 6'd15,
        ALU_BGEU = 6'd16,
        ALU_BEQ  = 6'd17,
        ALU_BNE  = 6'd18
    } alu_op_e;

    localparam logic [1:0] A_SEL_RS1  = 2'b00;
    localparam logic [1:0] A_SEL_PC   = 2'b01;
    localparam logic [1:0] A_SEL_PC4  = 2'b10;
    localparam logic [1:0] A_SEL_ZERO = 2'b11;

    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    function automatic logic fwd_hit(input logic       valid,
                                     input logic       reg_write,
                                     input logic [4:0] rd,
                                     input logic [4:0] idx);
        return valid & reg_write & (rd != 5'd0) & (rd == idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand bypass mux: EX/MEM result beats MEM/WB result beats the
// register-file data captured at ID; x0 always reads zero.
module fwd_unit #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      idx,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exm_valid,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_data
);
    import id_ex_stage_pkg::*;

    // Three-way priority select of the operand source
    always_comb begin
        fwd_data = reg_data;
        if (idx == 5'd0) begin
            fwd_data = '0;
        end else if (fwd_hit(exm_valid, exm_reg_write, exm_rd, idx)) begin
            fwd_data = exm_result;
        end else if (fwd_hit(wb_valid, wb_reg_write, wb_rd, idx)) begin
            fwd_data = wb_result;
        end else begin
            fwd_data = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, inserts load-use and
// flush bubbles, and presents bypassed, selected operands to the ALU.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [1:0]        id_a_sel,
    input  logic              id_b_sel,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [4:0]        exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_result,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic [XLEN-1:0]   operand_A,
    output logic [XLEN-1:0]   operand_B,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_pc
);
    import id_ex_stage_pkg::*;

    logic              ex_valid_r, ex_reg_write_r, ex_mem_read_r, ex_mem_write_r;
    logic              ex_b_sel_r, flush_pending_r;
    logic [CTRL_W-1:0] ex_alu_ctrl_r;
    logic [XLEN-1:0]   ex_pc_r, ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
    logic [4:0]        ex_rs1_r, ex_rs2_r, ex_rd_r;
    logic [1:0]        ex_a_sel_r;
    logic              stall_s, bubble_s;
    logic [XLEN-1:0]   rs1_fwd_s, rs2_fwd_s;

    // Load-use detection against the load currently in EX; a flush kills it
    always_comb begin
        stall_s = 1'b0;
        if (!flush && ex_valid_r && ex_mem_read_r && (ex_rd_r != 5'd0) && id_valid) begin
            stall_s = (id_uses_rs1 && (id_rs1 == ex_rd_r)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd_r));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign load_use_stall = stall_s;
    assign bubble_s       = flush | flush_pending_r | stall_s;

    // EX register update: hold > flush (incl. deferred) > load-use > load ID
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_r      <= 1'b0;
            ex_alu_ctrl_r   <= '0;
            ex_pc_r         <= '0;
            ex_rs1_data_r   <= '0;
            ex_rs2_data_r   <= '0;
            ex_imm_r        <= '0;
            ex_rs1_r        <= 5'd0;
            ex_rs2_r        <= 5'd0;
            ex_rd_r         <= 5'd0;
            ex_a_sel_r      <= A_SEL_RS1;
            ex_b_sel_r      <= B_SEL_RS2;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            flush_pending_r <= 1'b0;
        end else if (hold) begin
            if (flush) begin
                flush_pending_r <= 1'b1;
            end
        end else if (bubble_s) begin
            ex_valid_r      <= 1'b0;
            ex_alu_ctrl_r   <= '0;
            ex_pc_r         <= '0;
            ex_rs1_data_r   <= '0;
            ex_rs2_data_r   <= '0;
            ex_imm_r        <= '0;
            ex_rs1_r        <= 5'd0;
            ex_rs2_r        <= 5'd0;
            ex_rd_r         <= 5'd0;
            ex_a_sel_r      <= A_SEL_RS1;
            ex_b_sel_r      <= B_SEL_RS2;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            flush_pending_r <= 1'b0;
        end else begin
            ex_valid_r      <= id_valid;
            ex_alu_ctrl_r   <= id_alu_ctrl;
            ex_pc_r         <= id_pc;
            ex_rs1_data_r   <= id_rs1_data;
            ex_rs2_data_r   <= id_rs2_data;
            ex_imm_r        <= id_imm;
            ex_rs1_r        <= id_rs1;
            ex_rs2_r        <= id_rs2;
            ex_rd_r         <= id_rd;
            ex_a_sel_r      <= id_a_sel;
            ex_b_sel_r      <= id_b_sel;
            ex_reg_write_r  <= id_reg_write;
            ex_mem_read_r   <= id_mem_read;
            ex_mem_write_r  <= id_mem_write;
        end
    end

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .idx(ex_rs1_r), .reg_data(ex_rs1_data_r),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_result(wb_result),
        .fwd_data(rs1_fwd_s)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .idx(ex_rs2_r), .reg_data(ex_rs2_data_r),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_result(wb_result),
        .fwd_data(rs2_fwd_s)
    );

    // ALU operand selection from bypassed sources, PC and immediate
    always_comb begin
        operand_A = '0;
        case (ex_a_sel_r)
            A_SEL_RS1:  operand_A = rs1_fwd_s;
            A_SEL_PC:   operand_A = ex_pc_r;
            A_SEL_PC4:  operand_A = ex_pc_r + {{(XLEN-3){1'b0}}, 3'd4};
            A_SEL_ZERO: operand_A = '0;
            default:    operand_A = '0;
        endcase
        if (ex_b_sel_r == B_SEL_IMM) begin
            operand_B = ex_imm_r;
        end else begin
            operand_B = rs2_fwd_s;
        end
    end

    assign ex_store_data = rs2_fwd_s;
    assign ex_valid      = ex_valid_r;
    assign ALU_Control   = ex_alu_ctrl_r;
    assign ex_rd         = ex_rd_r;
    assign ex_reg_write  = ex_reg_write_r;
    assign ex_mem_read   = ex_mem_read_r;
    assign ex_mem_write  = ex_mem_write_r;
    assign ex_pc         = ex_pc_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pipeline capture, bypassing, load-use
// bubbles, hold/flush interplay, operand selection and async reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clock, reset_n, hold, flush;
    logic        id_valid;
    logic [5:0]  id_alu_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [1:0]  id_a_sel;
    logic        id_b_sel, id_reg_write, id_mem_read, id_mem_write;
    logic        exm_valid, exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        load_use_stall, ex_valid;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A, operand_B, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .CTRL_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ALU_Control(ALU_Control),
        .operand_A(operand_A), .operand_B(operand_B), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_pc(ex_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic id_idle();
        id_valid = 1'b0; id_alu_ctrl = 6'd0; id_pc = 32'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_a_sel = 2'b00; id_b_sel = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    endtask

    task automatic id_add_x3();
        id_idle();
        id_valid = 1'b1; id_alu_ctrl = 6'd1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
        id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic id_lw_x4();
        id_idle();
        id_valid = 1'b1; id_alu_ctrl = 6'd1; id_rs1 = 5'd1; id_rs1_data = 32'h100;
        id_imm = 32'd8; id_b_sel = 1'b1; id_rd = 5'd4;
        id_mem_read = 1'b1; id_reg_write = 1'b1; id_uses_rs1 = 1'b1;
    endtask

    task automatic id_add_x5_x4();
        id_idle();
        id_valid = 1'b1; id_alu_ctrl = 6'd1; id_rs1 = 5'd4; id_rs2 = 5'd1; id_rd = 5'd5;
        id_rs1_data = 32'h44; id_rs2_data = 32'd5;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic fwd_idle();
        exm_valid = 1'b0; exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0; hold = 1'b0; flush = 1'b0;
        id_idle();
        fwd_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_alu", {26'd0, ALU_Control}, 32'd0);
        chk("rst_opA", operand_A, 32'd0);
        chk("rst_opB", operand_B, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

        // ADD x3,x1,x2 with no hazards
        @(negedge clock);
        reset_n = 1'b1;
        id_add_x3();
        @(posedge clock); #1;
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_alu", {26'd0, ALU_Control}, 32'd1);
        chk("add_opA", operand_A, 32'd5);
        chk("add_opB", operand_B, 32'd7);
        chk("add_store", ex_store_data, 32'd7);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_rw", {31'd0, ex_reg_write}, 32'd1);

        // Bypassing with EX frozen by hold
        @(negedge clock);
        hold = 1'b1;
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd1; exm_result = 32'h10;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd1; wb_result = 32'h20;
        #1;
        chk("fwd_exm_wins", operand_A, 32'h10);
        @(negedge clock);
        exm_rd = 5'd0; wb_rd = 5'd0;
        #1;
        chk("fwd_x0_dest", operand_A, 32'd5);
        @(negedge clock);
        wb_rd = 5'd1;
        #1;
        chk("fwd_wb", operand_A, 32'h20);
        @(negedge clock);
        exm_rd = 5'd2;
        #1;
        chk("fwd_rs2_opB", operand_B, 32'h10);
        chk("fwd_rs2_store", ex_store_data, 32'h10);
        chk("hold_keeps_rd", {27'd0, ex_rd}, 32'd3);
        @(negedge clock);
        wb_reg_write = 1'b0;
        #1;
        chk("fwd_wb_nowrite", operand_A, 32'd5);
        @(negedge clock);
        hold = 1'b0;
        fwd_idle();

        // Load-use hazard
        id_lw_x4();
        @(posedge clock); #1;
        chk("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_opA", operand_A, 32'h100);
        chk("lw_opB", operand_B, 32'd8);
        @(negedge clock);
        id_add_x5_x4();
        #1;
        chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
        @(posedge clock); #1;
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bub_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        chk("lu_bub_alu", {26'd0, ALU_Control}, 32'd0);
        chk("lu_bub_rd", {27'd0, ex_rd}, 32'd0);
        chk("lu_stall_gone", {31'd0, load_use_stall}, 32'd0);
        @(posedge clock); #1;
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd5);
        chk("lu_add_opA", operand_A, 32'h44);
        chk("lu_add_opB", operand_B, 32'd5);

        // Flush beats a simultaneous load-use stall
        @(negedge clock);
        id_lw_x4();
        @(posedge clock);
        @(negedge clock);
        id_add_x5_x4();
        flush = 1'b1;
        #1;
        chk("fl_no_stall", {31'd0, load_use_stall}, 32'd0);
        @(posedge clock); #1;
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
        @(negedge clock);
        flush = 1'b0;
        @(posedge clock); #1;
        chk("fl_next_rd", {27'd0, ex_rd}, 32'd5);

        // Hold with flush for two cycles, then release
        @(negedge clock);
        hold = 1'b1; flush = 1'b1;
        id_idle();
        id_valid = 1'b1; id_alu_ctrl = 6'd2; id_rd = 5'd7; id_reg_write = 1'b1;
        @(posedge clock); #1;
        chk("hf1_rd", {27'd0, ex_rd}, 32'd5);
        chk("hf1_valid", {31'd0, ex_valid}, 32'd1);
        @(posedge clock); #1;
        chk("hf2_alu", {26'd0, ALU_Control}, 32'd1);
        @(negedge clock);
        hold = 1'b0; flush = 1'b0;
        @(posedge clock); #1;
        chk("hf_pending_bub", {31'd0, ex_valid}, 32'd0);
        @(posedge clock); #1;
        chk("hf_after_valid", {31'd0, ex_valid}, 32'd1);
        chk("hf_after_alu", {26'd0, ALU_Control}, 32'd2);

        // Operand-A/B selection
        @(negedge clock);
        id_idle();
        id_valid = 1'b1; id_alu_ctrl = 6'd9; id_pc = 32'h100; id_a_sel = 2'b10; id_rd = 5'd1;
        @(posedge clock); #1;
        chk("jal_opA", operand_A, 32'h104);
        chk("jal_pc", ex_pc, 32'h100);
        @(negedge clock);
        id_alu_ctrl = 6'd1; id_a_sel = 2'b01; id_b_sel = 1'b1; id_imm = 32'h1000;
        @(posedge clock); #1;
        chk("auipc_opA", operand_A, 32'h100);
        chk("auipc_opB", operand_B, 32'h1000);
        @(negedge clock);
        id_pc = 32'hFFFF_FFFC; id_a_sel = 2'b10;
        @(posedge clock); #1;
        chk("pc4_wrap", operand_A, 32'd0);
        @(negedge clock);
        id_a_sel = 2'b11; id_rs1 = 5'd6; id_rs1_data = 32'h66;
        id_rs2 = 5'd2; id_rs2_data = 32'h55; id_imm = 32'h77; id_b_sel = 1'b1;
        @(posedge clock); #1;
        chk("zero_opA", operand_A, 32'd0);
        chk("imm_opB", operand_B, 32'h77);
        chk("store_rs2", ex_store_data, 32'h55);

        // Asynchronous reset mid-stream
        @(negedge clock);
        id_add_x3();
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_alu", {26'd0, ALU_Control}, 32'd0);
        chk("arst_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        chk("arst_rd", {27'd0, ex_rd}, 32'd0);
        chk("arst_opA", operand_A, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_rd", {27'd0, ex_rd}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, sitting directly upstream of the ALU.
- Captures decoded instruction fields each cycle and applies EX/MEM and MEM/WB forwarding.
- Drives ALU_Control, operand_A and operand_B into the ALU.
- Detects load-use hazards, inserts bubbles, and honours downstream hold and branch flush.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 6, ALU_Control width (matches ALU op encoding)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  downstream stall; freeze EX register
- flush  in  1  taken branch/jump; squash the instruction entering EX
- id_valid  in  1  ID slot holds a real instruction
- id_alu_ctrl  in  CTRL_W  decoded ALU op
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_a_sel  in  2  00 rs1, 01 pc, 10 pc+4, 11 zero
- id_b_sel  in  1  0 rs2, 1 imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exm_valid, exm_reg_write  in  1  EX/MEM stage status
- exm_rd  in  5
- exm_result  in  XLEN
- wb_valid, wb_reg_write  in  1  MEM/WB stage status
- wb_rd  in  5
- wb_result  in  XLEN
- load_use_stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1
- ALU_Control  out  CTRL_W
- operand_A, operand_B  out  XLEN  forwarded, selected ALU inputs
- ex_store_data  out  XLEN  forwarded rs2 for SW
- ex_rd  out  5
- ex_reg_write, ex_mem_read, ex_mem_write  out  1
- ex_pc  out  XLEN

Behaviour:
- Reset (async, reset_n low): all EX registers clear.
  - ex_valid=0, ALU_Control=0, all control bits=0, ex_rd=0, ex_pc=0, flush_pending=0.
  - operand_A, operand_B and ex_store_data evaluate to 0 while in reset.
- Latency: one cycle. ID fields sampled on a rising edge appear on EX outputs that cycle.
- Bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_rd=0, ALU_Control=0. Data fields are don't-care but forced to 0.
- Load-use hazard (combinational):
  - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - load_use_stall is forced to 0 when flush=1.
- Register update priority each edge:
  1. hold=1: keep contents. If flush=1, set flush_pending=1.
  2. flush=1 or flush_pending=1: load bubble; clear flush_pending.
  3. load_use_stall=1: load bubble. ID is held upstream and re-presented next cycle.
  4. Otherwise load ID fields; ex_valid=id_valid.
- Forwarding (combinational, from the registered rs1/rs2 index and data):
  - Source is EX/MEM if exm_valid & exm_reg_write & exm_rd!=0 & exm_rd==idx.
  - Otherwise MEM/WB if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==idx.
  - Otherwise the registered file data. EX/MEM wins when both match. x0 always reads 0.
- Operand select:
  - operand_A: rs1_fwd / ex_pc / ex_pc+4 (mod 2^XLEN) / 0, per registered a_sel.
  - operand_B: rs2_fwd or imm, per registered b_sel.
  - ex_store_data = rs2_fwd regardless of b_sel.
- Hold with changing forward sources: operands re-evaluate every cycle, so a held instruction picks up the latest bypass values.
- Simultaneous flush and load_use_stall: flush wins. Result is a bubble and no stall.
- reset_n deasserting mid-stream: the first edge after release samples ID normally.

Decomposition:
- Shared package/defines:
  - ALU op codes: ADD, SUB, OR, XOR, AND, SLL, SRL, SRA, JAL, JALR, SLT, SLTU, BLT, BLTU, BGE, BGEU, BEQ, BNE.
  - A_SEL_* and B_SEL_* encodings.
  - XLEN.
- One sub-module: fwd_unit (per-operand 3-way bypass priority mux), instantiated twice for rs1 and rs2.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, no hazards -> next cycle ALU_Control=ADD, operand_A=5, operand_B=7, ex_valid=1.
- EX/MEM writing x1=0x10 and MEM/WB writing x1=0x20, EX reads x1 -> operand_A=0x10. Same case with exm_rd=0 -> operand_A=register data, not 0x20 from x0.
- LW x4 in EX, ID is ADD x5,x4,x1 -> load_use_stall=1 for one cycle, EX shows bubble (ex_valid=0, ex_reg_write=0), then ADD enters next cycle.
- hold=1 and flush=1 together for 2 cycles, then hold=0 -> EX contents unchanged during hold; first edge after release loads a bubble (flush_pending honoured).
- JAL at pc=0x100 with a_sel=10 -> operand_A=0x104. AUIPC with imm=0x1000 -> operand_A=0x100, operand_B=0x1000.
- reset_n pulled low mid-stream with valid EX contents -> immediately ex_valid=0, ALU_Control=0, all control outputs 0, without waiting for a clock edge.
